// File: rtl/program_mem_server.sv
// Program-memory responder: a 4-entry fetch-request FIFO in front of a single-port
// instruction RAM with a host load port. Optional range checking: PROGRAM_MEM_RANGE_CHECK_EN.
module program_mem_server #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 16,
  parameter int WID_BITS  = 2,
  parameter int MEM_DEPTH = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 program_mem_available_o,
  input  logic                 program_read_valid_i,
  input  logic [ADDR_BITS-1:0] program_read_addr_i,
  input  logic [WID_BITS-1:0]  program_read_wid_i,
  output logic                 program_read_ready_o,
  output logic [DATA_BITS-1:0] program_read_data_o,
  output logic [WID_BITS-1:0]  program_read_wid_o,
`ifdef PROGRAM_MEM_RANGE_CHECK_EN
  output logic                 program_read_err_o,
`endif
  input  logic                 load_valid_i,
  input  logic [ADDR_BITS-1:0] load_addr_i,
  input  logic [DATA_BITS-1:0] load_data_i
);

  localparam int IDX_BITS = $clog2(MEM_DEPTH);

  // Handshake: a request transfers on a rising edge where program_read_valid_i and
  // program_mem_available_o are both high; the response is a one-cycle
  // program_read_ready_o pulse with no backpressure, always in request order.

  logic [DATA_BITS-1:0] mem [MEM_DEPTH];
  logic [ADDR_BITS-1:0] fifo_addr [4];
  logic [WID_BITS-1:0]  fifo_wid [4];
  logic [1:0]           wr_ptr;
  logic [1:0]           rd_ptr;
  logic [2:0]           count;
  logic                 push;
  logic                 pop;
  logic [ADDR_BITS-1:0] head_addr;
  logic [WID_BITS-1:0]  head_wid;
  logic [IDX_BITS-1:0]  head_idx;
  logic [IDX_BITS-1:0]  load_idx;
  logic                 head_oor;
  logic                 load_oor;
  logic                 load_we;

  assign program_mem_available_o = !rst && (count != 3'd4);
  assign push      = program_read_valid_i && program_mem_available_o;
  // The RAM has one port, so a host load takes it and the pop waits.
  assign pop       = (count != 3'd0) && !load_valid_i;
  assign head_addr = fifo_addr[rd_ptr];
  assign head_wid  = fifo_wid[rd_ptr];
  assign head_idx  = head_addr[IDX_BITS-1:0];
  assign load_idx  = load_addr_i[IDX_BITS-1:0];

`ifdef PROGRAM_MEM_RANGE_CHECK_EN
  if (IDX_BITS < ADDR_BITS) begin : g_range
    assign head_oor = |head_addr[ADDR_BITS-1:IDX_BITS];
    assign load_oor = |load_addr_i[ADDR_BITS-1:IDX_BITS];
  end else begin : g_no_range
    assign head_oor = 1'b0;
    assign load_oor = 1'b0;
  end
`else
  logic unused_addr_hi;
  assign head_oor       = 1'b0;
  assign load_oor       = 1'b0;
  assign unused_addr_hi = ^{head_addr, load_addr_i};
`endif

  assign load_we = load_valid_i && !load_oor;

  always_ff @(posedge clk) begin
    if (load_we) mem[load_idx] <= load_data_i;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= program_read_addr_i;
      fifo_wid[wr_ptr]  <= program_read_wid_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      program_read_ready_o <= 1'b0;
      program_read_data_o  <= '0;
      program_read_wid_o   <= '0;
`ifdef PROGRAM_MEM_RANGE_CHECK_EN
      program_read_err_o   <= 1'b0;
`endif
    end else begin
      program_read_ready_o <= pop;
      if (pop) begin
        program_read_wid_o  <= head_wid;
        program_read_data_o <= head_oor ? '0 : mem[head_idx];
`ifdef PROGRAM_MEM_RANGE_CHECK_EN
        program_read_err_o  <= head_oor;
`endif
      end
    end
  end

endmodule

// File: tb/tb_program_mem_server.sv
// Directed bench for program_mem_server: latency, throughput, load stalls,
// FIFO full/retry, reset flush and address aliasing with a 128-word RAM.
module tb_program_mem_server;
  localparam int AB = 8;
  localparam int DB = 16;
  localparam int WB = 2;
  localparam int DEPTH = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          available;
  logic          rd_valid;
  logic [AB-1:0] rd_addr;
  logic [WB-1:0] rd_wid;
  logic          rd_ready;
  logic [DB-1:0] rd_data;
  logic [WB-1:0] rd_wid_out;
  logic          rd_err;
  logic          ld_valid;
  logic [AB-1:0] ld_addr;
  logic [DB-1:0] ld_data;
  logic [DB-1:0] exp72;
  logic [DB-1:0] exp200;
  logic          exp_err200;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  program_mem_server #(
    .ADDR_BITS(AB), .DATA_BITS(DB), .WID_BITS(WB), .MEM_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .program_mem_available_o(available),
    .program_read_valid_i(rd_valid),
    .program_read_addr_i(rd_addr),
    .program_read_wid_i(rd_wid),
    .program_read_ready_o(rd_ready),
    .program_read_data_o(rd_data),
    .program_read_wid_o(rd_wid_out),
`ifdef PROGRAM_MEM_RANGE_CHECK_EN
    .program_read_err_o(rd_err),
`endif
    .load_valid_i(ld_valid),
    .load_addr_i(ld_addr),
    .load_data_i(ld_data)
  );

`ifndef PROGRAM_MEM_RANGE_CHECK_EN
  assign rd_err = 1'b0;
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, {31'd0, rd_ready}, 32'd0);
  endtask

  task automatic chk_resp(input string tag, input logic [DB-1:0] d, input logic [WB-1:0] w);
    chk({tag, "_ready"}, {31'd0, rd_ready}, 32'd1);
    chk({tag, "_data"}, {16'd0, rd_data}, {16'd0, d});
    chk({tag, "_wid"}, {30'd0, rd_wid_out}, {30'd0, w});
    chk({tag, "_err"}, {31'd0, rd_err}, 32'd0);
  endtask

  task automatic load(input logic [AB-1:0] a, input logic [DB-1:0] d);
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_data  = d;
    step();
    ld_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rd_valid = 1'b0; rd_addr = '0; rd_wid = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
    step();
    step();
    chk("rst_ready", {31'd0, rd_ready}, 32'd0);
    chk("rst_data", {16'd0, rd_data}, 32'd0);
    chk("rst_wid", {30'd0, rd_wid_out}, 32'd0);
    chk("rst_err", {31'd0, rd_err}, 32'd0);
    chk("rst_avail", {31'd0, available}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_avail", {31'd0, available}, 32'd1);

    // Single fetch: response exactly two edges after acceptance.
    load(8'd5, 16'hA5A5);
    rd_valid = 1'b1; rd_addr = 8'd5; rd_wid = 2'd2;
    step();
    rd_valid = 1'b0;
    chk_idle("lat_n1");
    step();
    chk_resp("lat_n2", 16'hA5A5, 2'd2);
    step();
    chk_idle("lat_n3");

    // Back-to-back stream 0..4, one response per cycle.
    for (int i = 0; i < 5; i++) load(i[AB-1:0], 16'h1000 + i[DB-1:0]);
    for (int i = 0; i < 5; i++) begin
      rd_valid = 1'b1;
      rd_addr  = i[AB-1:0];
      rd_wid   = (i == 4) ? 2'd0 : i[WB-1:0];
      step();
      if (i == 0) chk_idle("b2b_first");
      else chk_resp("b2b", 16'h1000 + i[DB-1:0] - 16'd1, i[WB-1:0] - 2'd1);
    end
    rd_valid = 1'b0;
    step();
    chk_resp("b2b_last", 16'h1004, 2'd0);
    step();
    chk_idle("b2b_done");

    // Three load cycles with two requests queued delay both by three cycles.
    rd_valid = 1'b1; rd_addr = 8'd7; rd_wid = 2'd1;
    step();
    chk_idle("ld_e1");
    ld_valid = 1'b1; ld_addr = 8'd7; ld_data = 16'h7777;
    rd_addr = 8'd4; rd_wid = 2'd3;
    step();
    chk_idle("ld_e2");
    rd_valid = 1'b0; ld_addr = 8'd8; ld_data = 16'h8888;
    step();
    chk_idle("ld_e3");
    ld_addr = 8'd9; ld_data = 16'h9999;
    step();
    chk_idle("ld_e4");
    ld_valid = 1'b0;
    step();
    chk_resp("ld_r1", 16'h7777, 2'd1);
    step();
    chk_resp("ld_r2", 16'h1004, 2'd3);
    step();
    chk_idle("ld_done");
    rd_valid = 1'b1; rd_addr = 8'd8; rd_wid = 2'd0;
    step();
    rd_valid = 1'b0;
    step();
    chk_resp("raw_8", 16'h8888, 2'd0);

    // Fill to four under a load stall, reject a fifth, then retry it.
    ld_valid = 1'b1; ld_addr = 8'd9; ld_data = 16'h9999;
    for (int i = 0; i < 4; i++) begin
      rd_valid = 1'b1; rd_addr = i[AB-1:0]; rd_wid = i[WB-1:0];
      step();
    end
    chk("full_avail", {31'd0, available}, 32'd0);
    rd_addr = 8'd4; rd_wid = 2'd2;
    step();
    chk("full_avail2", {31'd0, available}, 32'd0);
    chk_idle("full_idle");
    ld_valid = 1'b0;
    step();
    chk("pop_avail", {31'd0, available}, 32'd1);
    chk_resp("full_r0", 16'h1000, 2'd0);
    step();
    rd_valid = 1'b0;
    chk_resp("full_r1", 16'h1001, 2'd1);
    step();
    chk_resp("full_r2", 16'h1002, 2'd2);
    step();
    chk_resp("full_r3", 16'h1003, 2'd3);
    step();
    chk_resp("full_retry", 16'h1004, 2'd2);
    step();
    chk_idle("full_done");

    // Reset with three requests pending flushes them; RAM survives.
    ld_valid = 1'b1; ld_addr = 8'd9; ld_data = 16'h9999;
    rd_valid = 1'b1; rd_addr = 8'd5; rd_wid = 2'd1;
    for (int i = 0; i < 3; i++) step();
    rd_valid = 1'b0; ld_valid = 1'b0; rst = 1'b1;
    step();
    chk("mrst_ready", {31'd0, rd_ready}, 32'd0);
    chk("mrst_data", {16'd0, rd_data}, 32'd0);
    chk("mrst_wid", {30'd0, rd_wid_out}, 32'd0);
    chk("mrst_avail", {31'd0, available}, 32'd0);
    rst = 1'b0;
    #1;
    chk("mrst_avail_after", {31'd0, available}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_idle("mrst_flush");
    end
    rd_valid = 1'b1; rd_addr = 8'd5; rd_wid = 2'd3;
    step();
    rd_valid = 1'b0;
    step();
    chk_resp("mrst_mem5", 16'hA5A5, 2'd3);

    // Out-of-range address 200 with a 128-word RAM.
`ifdef PROGRAM_MEM_RANGE_CHECK_EN
    exp72 = 16'h4848; exp200 = 16'h0000; exp_err200 = 1'b1;
`else
    exp72 = 16'hBEEF; exp200 = 16'hBEEF; exp_err200 = 1'b0;
`endif
    load(8'd72, 16'h4848);
    load(8'd200, 16'hBEEF);
    rd_valid = 1'b1; rd_addr = 8'd72; rd_wid = 2'd1;
    step();
    rd_addr = 8'd200; rd_wid = 2'd2;
    step();
    rd_valid = 1'b0;
    chk_resp("oor_72", exp72, 2'd1);
    step();
    chk("oor_200_ready", {31'd0, rd_ready}, 32'd1);
    chk("oor_200_data", {16'd0, rd_data}, {16'd0, exp200});
    chk("oor_200_wid", {30'd0, rd_wid_out}, 32'd2);
    chk("oor_200_err", {31'd0, rd_err}, {31'd0, exp_err200});
    step();
    chk_idle("oor_done");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
